// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Producer result channels, pipeline control and common data
//                bus broadcast grouped for the CDB arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH_BIT = 4
);
  logic                     rdy_in;
  logic                     clear_in;

  logic                     alu_valid;
  logic [ROB_WIDTH_BIT-1:0] alu_rob_id;
  logic [31:0]              alu_value;
  logic                     alu_ready;

  logic                     lsb_valid;
  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id;
  logic [31:0]              lsb_value;
  logic                     lsb_ready;

  logic                     br_valid;
  logic [ROB_WIDTH_BIT-1:0] br_rob_id;
  logic [31:0]              br_value;
  logic                     br_ready;

  logic                     cdb_valid;
  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id;
  logic [31:0]              cdb_value;
  logic [1:0]               cdb_src;
  logic                     busy;

  // Arbiter side
  modport slave (
    input  rdy_in, clear_in,
    input  alu_valid, alu_rob_id, alu_value,
    output alu_ready,
    input  lsb_valid, lsb_rob_id, lsb_value,
    output lsb_ready,
    input  br_valid, br_rob_id, br_value,
    output br_ready,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_src, busy
  );

  // Producer / ROB side
  modport master (
    output rdy_in, clear_in,
    output alu_valid, alu_rob_id, alu_value,
    input  alu_ready,
    output lsb_valid, lsb_rob_id, lsb_value,
    input  lsb_ready,
    output br_valid, br_rob_id, br_value,
    input  br_ready,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_src, busy
  );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Three small per-producer FIFOs feeding a round-robin arbiter
//                that drives a registered common data bus broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int ROB_WIDTH_BIT  = 4,
  parameter int FIFO_DEPTH_BIT = 1
) (
  input  wire               clk_in,
  input  wire               rst_in,
  cdb_arbiter_if.slave      bus
);

  localparam int                      c_num_src = 3;
  localparam logic [FIFO_DEPTH_BIT:0] c_depth   = (FIFO_DEPTH_BIT+1)'(1 << FIFO_DEPTH_BIT);

  logic [c_num_src-1:0]     w_in_valid;
  logic [ROB_WIDTH_BIT-1:0] w_in_id   [c_num_src];
  logic [31:0]              w_in_val  [c_num_src];
  logic [ROB_WIDTH_BIT-1:0] w_head_id [c_num_src];
  logic [31:0]              w_head_val[c_num_src];
  logic [c_num_src-1:0]     w_ready;
  logic [c_num_src-1:0]     w_nonempty;
  logic [c_num_src-1:0]     w_push;
  logic [c_num_src-1:0]     w_pop;
  logic                     w_advance;
  logic                     w_any;
  logic [1:0]               w_winner;

  logic                     r_cdb_valid;
  logic [ROB_WIDTH_BIT-1:0] r_cdb_rob_id;
  logic [31:0]              r_cdb_value;
  logic [1:0]               r_cdb_src;
  logic [1:0]               r_last_grant;

  // Index 0 = ALU, 1 = LSB, 2 = branch unit
  assign w_in_valid  = {bus.br_valid, bus.lsb_valid, bus.alu_valid};
  assign w_in_id[0]  = bus.alu_rob_id;
  assign w_in_id[1]  = bus.lsb_rob_id;
  assign w_in_id[2]  = bus.br_rob_id;
  assign w_in_val[0] = bus.alu_value;
  assign w_in_val[1] = bus.lsb_value;
  assign w_in_val[2] = bus.br_value;

  // A flush overrides the ready line; nothing moves while stalled
  assign w_advance = bus.rdy_in & ~bus.clear_in;

  genvar gi;
  generate
    for (gi = 0; gi < c_num_src; gi++) begin : g_fifo
      localparam logic [FIFO_DEPTH_BIT-1:0] c_ptr_one = 1;
      localparam logic [FIFO_DEPTH_BIT:0]   c_cnt_one = 1;

      logic [ROB_WIDTH_BIT-1:0]  r_mem_id [1 << FIFO_DEPTH_BIT];
      logic [31:0]               r_mem_val[1 << FIFO_DEPTH_BIT];
      logic [FIFO_DEPTH_BIT-1:0] r_head;
      logic [FIFO_DEPTH_BIT-1:0] r_tail;
      logic [FIFO_DEPTH_BIT:0]   r_count;

      // Ready looks only at the registered count, so a same-cycle pop never frees a slot
      assign w_ready[gi]    = (r_count != c_depth);
      assign w_nonempty[gi] = (r_count != '0);
      assign w_push[gi]     = w_in_valid[gi] & w_ready[gi] & w_advance;
      assign w_pop[gi]      = w_advance & w_any & (w_winner == 2'(gi));
      assign w_head_id[gi]  = r_mem_id[r_head];
      assign w_head_val[gi] = r_mem_val[r_head];

      // Entry storage: written at the tail on every accepted push
      always_ff @(posedge clk_in) begin
        if (w_push[gi]) begin
          r_mem_id[r_tail]  <= w_in_id[gi];
          r_mem_val[r_tail] <= w_in_val[gi];
        end
      end

      // Pointer and occupancy tracking; a flush empties the FIFO
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
        end else if (bus.clear_in) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
        end else if (bus.rdy_in) begin
          if (w_push[gi]) r_tail <= r_tail + c_ptr_one;
          if (w_pop[gi])  r_head <= r_head + c_ptr_one;
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // Round-robin search starting just after the last granted source
  always_comb begin
    w_any    = |w_nonempty;
    w_winner = 2'd0;
    case (r_last_grant)
      2'd0: begin
        if      (w_nonempty[1]) w_winner = 2'd1;
        else if (w_nonempty[2]) w_winner = 2'd2;
        else                    w_winner = 2'd0;
      end
      2'd1: begin
        if      (w_nonempty[2]) w_winner = 2'd2;
        else if (w_nonempty[0]) w_winner = 2'd0;
        else                    w_winner = 2'd1;
      end
      default: begin
        if      (w_nonempty[0]) w_winner = 2'd0;
        else if (w_nonempty[1]) w_winner = 2'd1;
        else                    w_winner = 2'd2;
      end
    endcase
  end

  // Registered broadcast; payload and grant pointer hold when nothing is popped
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= 2'd0;
      r_last_grant <= 2'd2;
    end else if (bus.clear_in) begin
      r_cdb_valid  <= 1'b0;
    end else if (bus.rdy_in) begin
      if (w_any) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_rob_id <= w_head_id[w_winner];
        r_cdb_value  <= w_head_val[w_winner];
        r_cdb_src    <= w_winner;
        r_last_grant <= w_winner;
      end else begin
        r_cdb_valid  <= 1'b0;
      end
    end
  end

  assign bus.alu_ready  = w_ready[0];
  assign bus.lsb_ready  = w_ready[1];
  assign bus.br_ready   = w_ready[2];
  assign bus.cdb_valid  = r_cdb_valid;
  assign bus.cdb_rob_id = r_cdb_rob_id;
  assign bus.cdb_value  = r_cdb_value;
  assign bus.cdb_src    = r_cdb_src;
  assign bus.busy       = r_cdb_valid | (|w_nonempty);

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Directed self-checking bench for the CDB arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic clk_in;
  logic rst_in;
  int   n_tests;
  int   n_fail;

  cdb_arbiter_if #(.ROB_WIDTH_BIT(4)) bus ();

  cdb_arbiter #(
    .ROB_WIDTH_BIT (4),
    .FIFO_DEPTH_BIT(1)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus.slave)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic put(input int s, input bit v, input logic [3:0] id, input logic [31:0] val);
    case (s)
      0: begin bus.alu_valid = v; bus.alu_rob_id = id; bus.alu_value = val; end
      1: begin bus.lsb_valid = v; bus.lsb_rob_id = id; bus.lsb_value = val; end
      default: begin bus.br_valid = v; bus.br_rob_id = id; bus.br_value = val; end
    endcase
  endtask

  logic [1:0]  exp_src [6];
  logic [31:0] exp_val [3];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_src = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    exp_val = '{32'hA0, 32'hB0, 32'hC0};
    rst_in       = 1'b0;
    bus.rdy_in   = 1'b1;
    bus.clear_in = 1'b0;
    put(0, 0, 0, 0); put(1, 0, 0, 0); put(2, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_valid", bus.cdb_valid, 0);
    chk("rst_rob",   bus.cdb_rob_id, 0);
    chk("rst_value", bus.cdb_value, 0);
    chk("rst_src",   bus.cdb_src, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_ready", {bus.alu_ready, bus.lsb_ready, bus.br_ready}, 3'b111);
    step(); step();
    rst_in = 1'b1;

    // 1: single ALU result, one-cycle latency after the sampling edge
    put(0, 1, 4'd3, 32'h11);
    step();
    put(0, 0, 0, 0);
    chk("t1_not_yet", bus.cdb_valid, 0);
    chk("t1_busy_q",  bus.busy, 1);
    step();
    chk("t1_valid", bus.cdb_valid, 1);
    chk("t1_rob",   bus.cdb_rob_id, 3);
    chk("t1_value", bus.cdb_value, 32'h11);
    chk("t1_src",   bus.cdb_src, 0);
    step();
    chk("t1_idle_valid", bus.cdb_valid, 0);
    chk("t1_idle_busy",  bus.busy, 0);

    // 2: all three saturate; last grant was ALU so LSB goes first
    put(0, 1, 4'd1, 32'hA0); put(1, 1, 4'd2, 32'hB0); put(2, 1, 4'd4, 32'hC0);
    step();
    for (int g = 0; g < 6; g++) begin
      step();
      chk("t2_valid", bus.cdb_valid, 1);
      chk("t2_src",   bus.cdb_src, exp_src[g]);
      chk("t2_value", bus.cdb_value, exp_val[exp_src[g]]);
    end
    put(0, 0, 0, 0); put(1, 0, 0, 0); put(2, 0, 0, 0);
    for (int k = 0; k < 12 && bus.busy; k++) step();
    chk("t2_drained", bus.busy, 0);

    // 3: LSB fills to two entries while ALU/branch keep competing
    put(0, 1, 4'd6, 32'hA1); put(1, 1, 4'd8, 32'h20); put(2, 1, 4'd7, 32'hC1);
    step();
    put(1, 1, 4'd9, 32'h21);
    chk("t3_ready_c1", bus.lsb_ready, 1);
    step();
    chk("t3_src_e2", bus.cdb_src, 0);
    put(1, 1, 4'd10, 32'h22);
    chk("t3_ready_full", bus.lsb_ready, 0);
    step();
    chk("t3_src_e3",   bus.cdb_src, 1);
    chk("t3_first",    bus.cdb_value, 32'h20);
    chk("t3_rob_e3",   bus.cdb_rob_id, 8);
    chk("t3_ready_re", bus.lsb_ready, 1);
    step();
    chk("t3_src_e4", bus.cdb_src, 2);
    put(1, 0, 0, 0);
    step();
    chk("t3_src_e5", bus.cdb_src, 0);
    step();
    chk("t3_second", bus.cdb_value, 32'h21);
    chk("t3_rob_e6", bus.cdb_rob_id, 9);
    step(); step();
    step();
    chk("t3_third",  bus.cdb_value, 32'h22);
    chk("t3_rob_e9", bus.cdb_rob_id, 10);

    // 4: four entries queued, then a flush with a same-cycle push
    chk("t4_busy_pre", bus.busy, 1);
    put(0, 0, 0, 0); put(2, 0, 0, 0);
    put(1, 1, 4'd12, 32'hDD);
    bus.clear_in = 1'b1;
    step();
    bus.clear_in = 1'b0;
    put(1, 0, 0, 0);
    chk("t4_valid", bus.cdb_valid, 0);
    chk("t4_busy",  bus.busy, 0);
    chk("t4_ready", {bus.alu_ready, bus.lsb_ready, bus.br_ready}, 3'b111);
    step();
    chk("t4_no_ghost", bus.cdb_valid, 0);
    chk("t4_busy2",    bus.busy, 0);

    // 5: stall with a live broadcast and a queued ALU entry
    put(2, 1, 4'd5, 32'h55); put(0, 1, 4'd13, 32'h66);
    step();
    put(2, 0, 0, 0); put(0, 0, 0, 0);
    step();
    chk("t5_valid", bus.cdb_valid, 1);
    chk("t5_rob",   bus.cdb_rob_id, 5);
    chk("t5_src",   bus.cdb_src, 2);
    bus.rdy_in = 1'b0;
    put(1, 1, 4'd14, 32'hEE);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_hold_valid", bus.cdb_valid, 1);
      chk("t5_hold_rob",   bus.cdb_rob_id, 5);
      chk("t5_hold_busy",  bus.busy, 1);
    end
    bus.rdy_in = 1'b1;
    put(1, 0, 0, 0);
    step();
    chk("t5_resume_src",   bus.cdb_src, 0);
    chk("t5_resume_rob",   bus.cdb_rob_id, 13);
    chk("t5_resume_value", bus.cdb_value, 32'h66);
    step();
    chk("t5_no_stall_push", bus.cdb_valid, 0);
    chk("t5_idle_busy",     bus.busy, 0);

    // 6: asynchronous reset between clock edges
    put(0, 1, 4'd1, 32'h31); put(1, 1, 4'd2, 32'h32);
    step();
    put(0, 0, 0, 0); put(1, 0, 0, 0);
    step();
    chk("t6_pre_valid", bus.cdb_valid, 1);
    chk("t6_pre_src",   bus.cdb_src, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("t6_rst_valid", bus.cdb_valid, 0);
    chk("t6_rst_busy",  bus.busy, 0);
    chk("t6_rst_rob",   bus.cdb_rob_id, 0);
    chk("t6_rst_ready", {bus.alu_ready, bus.lsb_ready, bus.br_ready}, 3'b111);
    #1 rst_in = 1'b1;
    put(2, 1, 4'd7, 32'h77); put(0, 1, 4'd3, 32'h33);
    step();
    put(2, 0, 0, 0); put(0, 0, 0, 0);
    step();
    chk("t6_first_src", bus.cdb_src, 0);
    chk("t6_first_rob", bus.cdb_rob_id, 3);
    chk("t6_first_val", bus.cdb_value, 32'h33);
    step();
    chk("t6_second_src", bus.cdb_src, 2);
    chk("t6_second_rob", bus.cdb_rob_id, 7);
    step();
    chk("t6_end_valid", bus.cdb_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
